dffram_dp: RTL and testbench
============================

DFFRAM_DP -- requirements
Module: dffram_dp

Interface
REQ-001 SHALL have parameter DW, default 32, data width in bits; multiple of 8.
REQ-002 SHALL have parameter DEPTH, default 4096, number of words; need not be a power of 2.
REQ-003 SHALL have parameter AW, default $clog2(DEPTH), address width.
REQ-004 SHALL have parameter NB, default DW/8, byte lanes per word.
REQ-005 SHALL have parameter INIT_FILE, default "" (empty), hex preload file loaded at time 0 when non-empty.
REQ-006 SHALL have parameter CLEAR_ON_RESET, default 0; 1 = zero-fill the array after every reset.
REQ-007 SHALL have parameter RDW_MODE, default READ_FIRST, same-port read-during-write result: READ_FIRST or WRITE_THROUGH.
REQ-008 SHALL use one clock and a synchronous active-high reset, with ports: CLK  in  1  clock; RST  in  1  synchronous active-high reset.
REQ-009 SHALL have, per port x in {A,B}: EN_x in 1 request; WE_x in NB byte write mask; A_x in AW word address; Di_x in DW write data.
REQ-010 SHALL have, per port x: GNT_x out 1 request accepted; Do_x out DW read data; RVALID_x out 1 Do_x valid; ERR_x out 1 out-of-range access.
REQ-011 SHALL have BUSY out 1, high while the array is unavailable (reset or zero-fill).

Function
REQ-012 SHALL run a controller with states RST_ST, INIT, READY; RST high forces RST_ST in the same cycle.
REQ-013 SHALL transition RST_ST to INIT on RST low if CLEAR_ON_RESET=1, otherwise to READY.
REQ-014 SHALL, in INIT, write zero to word cnt each cycle, cnt running 0..DEPTH-1; go to READY after cnt=DEPTH-1, so BUSY is high for exactly DEPTH cycles after RST falls.
REQ-015 SHALL hold GNT_x = EN_x & (state==READY); requests made while not READY are dropped, not queued.
REQ-016 SHALL, on a granted access, write byte lane i (Di_x[8i+7:8i]) when WE_x[i]=1; untouched lanes keep their contents.
REQ-017 SHALL provide one-cycle read latency: every granted access, write or read, updates Do_x and pulses RVALID_x for one cycle on the next cycle.
REQ-018 SHALL hold Do_x at its last value when no granted access occurred.
REQ-019 SHALL, on a same-port read-during-write, return pre-write data on Do_x if READ_FIRST, merged post-write data if WRITE_THROUGH.
REQ-020 SHALL, when both ports write the same address in one cycle, give port A priority per byte lane where both masks are set; lanes written by only one port take that port's data.
REQ-021 SHALL, on a cross-port read of an address the other port writes in that cycle, return the old data.
REQ-022 SHALL treat A_x >= DEPTH as out of range: ignore the write, set Do_x to 0, and raise ERR_x together with RVALID_x.
REQ-023 SHALL have no wrap-around of addresses.

Reset
REQ-024 SHALL drive Do_x=0, RVALID_x=0, ERR_x=0, GNT_x=0, BUSY=1 and cnt=0 during the RST cycle and the cycle after it.
REQ-025 SHALL, when RST is asserted during INIT, restart the zero-fill at word 0.
REQ-026 SHALL, when RST is asserted during READY, not perform a write presented in that cycle and drop a pending RVALID on the next cycle.
REQ-027 SHALL not alter array contents on reset unless CLEAR_ON_RESET=1.
REQ-028 SHALL flag an elaboration error for INIT_FILE non-empty together with CLEAR_ON_RESET=1, and for DW not a multiple of 8.

Structure
REQ-029 SHALL place rdw_mode_e (READ_FIRST, WRITE_THROUGH) and ram_state_e (RST_ST, INIT, READY) in shared package dffram_pkg.
REQ-030 SHALL implement the state machine and zero-fill counter in sub-module dffram_init_ctrl (outputs: state, cnt, BUSY).
REQ-031 SHALL keep the memory array and per-port logic in dffram_dp, with the array behavioural and inferable.

Verification
REQ-032 SHALL cover: DEPTH=16, CLEAR_ON_RESET=1 -> BUSY high for exactly 16 cycles after RST falls; read of word 5 returns 0x00000000.
REQ-033 SHALL cover: write 0xDEADBEEF to A_A=3 with WE_A=4'b1111, then WE_A=4'b0010 with Di_A=0x00001200 -> read of 3 returns 0xDEAD12EF one cycle later, with RVALID_A high.
REQ-034 SHALL cover: both ports write 0x11111111 (A) and 0x22222222 (B) to word 7 in one cycle -> word 7 reads 0x11111111; with WE_A=4'b0001 and WE_B=4'b1111 it reads 0x22222211.
REQ-035 SHALL cover: word 2 holds 0xAAAA5555, write 0x12345678 to word 2 with simultaneous read -> Do_A=0xAAAA5555 if READ_FIRST, 0x12345678 if WRITE_THROUGH.
REQ-036 SHALL cover: DEPTH=12, read A_B=13 -> Do_B=0, ERR_B and RVALID_B high for one cycle, memory unchanged.
REQ-037 SHALL cover: RST pulsed at cnt=9 of INIT -> fill restarts at 0; BUSY stays high for DEPTH cycles after the second RST fall.

Source files
------------

// File: rtl/dffram_pkg.sv
// Shared types for the dual-port DFF RAM slice.
//   rdw_mode_e  : same-port read-during-write behaviour (READ_FIRST / WRITE_THROUGH)
//   ram_state_e : array availability controller states (RST_ST / INIT / READY)
package dffram_pkg;

   localparam int unsigned BYTE_W = 8;

   typedef enum logic {
      READ_FIRST,
      WRITE_THROUGH
   } rdw_mode_e;

   typedef enum logic [1:0] {
      RST_ST,
      INIT,
      READY
   } ram_state_e;

endpackage

// File: rtl/dffram_init_ctrl.sv
// Availability controller for dffram_dp: reset handling and optional zero-fill sweep.
// Ports:
//   CLK, RST : clock, synchronous active-high reset
//   state    : current controller state (forced to RST_ST while RST is high)
//   cnt      : zero-fill word index, valid while state == INIT
//   BUSY     : high whenever the array is not READY
module dffram_init_ctrl
   import dffram_pkg::*;
#(
   parameter int unsigned DEPTH          = 4096,
   parameter int unsigned AW             = $clog2(DEPTH),
   parameter bit          CLEAR_ON_RESET = 1'b0
) (
   input  logic          CLK,
   input  logic          RST,
   output ram_state_e    state,
   output logic [AW-1:0] cnt,
   output logic          BUSY
);

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

   ram_state_e    state_q, state_d;
   logic [AW-1:0] cnt_q, cnt_d;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         RST_ST: begin
            state_d = CLEAR_ON_RESET ? INIT : READY;
            cnt_d   = '0;
         end
         INIT: begin
            if (cnt_q == LAST) begin
               state_d = READY;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + AW'(1);
            end
         end
         READY:   state_d = READY;
         default: state_d = RST_ST;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= RST_ST;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // RST overrides the registered state in the cycle it is asserted, so a
   // request or fill write presented alongside RST is never acted upon.
   assign state = RST ? RST_ST : state_q;
   assign cnt   = RST ? '0 : cnt_q;
   assign BUSY  = (state != READY);

endmodule

// File: rtl/dffram_dp.sv
module dffram_dp
  import dffram_pkg::*;
#(
  parameter int unsigned DW             = 32,
  parameter int unsigned DEPTH          = 4096,
  parameter int unsigned AW             = $clog2(DEPTH),
  parameter int unsigned NB             = DW / 8,
  parameter string       INIT_FILE      = "",
  parameter bit          CLEAR_ON_RESET = 1'b0,
  parameter rdw_mode_e   RDW_MODE       = READ_FIRST
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          EN_A,
  input  logic [NB-1:0] WE_A,
  input  logic [AW-1:0] A_A,
  input  logic [DW-1:0] Di_A,
  output logic          GNT_A,
  output logic [DW-1:0] Do_A,
  output logic          RVALID_A,
  output logic          ERR_A,
  input  logic          EN_B,
  input  logic [NB-1:0] WE_B,
  input  logic [AW-1:0] A_B,
  input  logic [DW-1:0] Di_B,
  output logic          GNT_B,
  output logic [DW-1:0] Do_B,
  output logic          RVALID_B,
  output logic          ERR_B,
  output logic          BUSY
);

  localparam int unsigned NP = 2;

  if (DW % BYTE_W != 0) begin : g_dw_err
    $error("dffram_dp: DW must be a multiple of 8");
  end
  if ((INIT_FILE != "") && CLEAR_ON_RESET) begin : g_cfg_err
    $error("dffram_dp: INIT_FILE cannot be combined with CLEAR_ON_RESET");
  end

  logic [DW-1:0] mem [DEPTH];

  ram_state_e    state;
  logic [AW-1:0] fill_cnt;

  logic [NP-1:0]         en, gnt, oor;
  logic [NP-1:0][NB-1:0] we, wr_lanes;
  logic [NP-1:0][AW-1:0] addr;
  logic [NP-1:0][DW-1:0] di, do_d, do_q;
  logic [NP-1:0]         rvalid_d, rvalid_q, err_d, err_q;

  dffram_init_ctrl #(
    .DEPTH          (DEPTH),
    .AW             (AW),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_ctrl (
    .CLK   (CLK),
    .RST   (RST),
    .state (state),
    .cnt   (fill_cnt),
    .BUSY  (BUSY)
  );

  assign en   = {EN_B, EN_A};
  assign we   = {WE_B, WE_A};
  assign addr = {A_B, A_A};
  assign di   = {Di_B, Di_A};

  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      gnt[p]      = en[p] && (state == READY);
      oor[p]      = (32'(addr[p]) >= DEPTH);
      wr_lanes[p] = (gnt[p] && !oor[p]) ? we[p] : '0;
    end
  end

  // Read path samples the array before this cycle's writes land, which gives
  // old data for cross-port reads; WRITE_THROUGH only merges the own port's lanes.
  always_comb begin
    for (int unsigned p = 0; p < NP; p++) begin
      do_d[p]     = do_q[p];
      rvalid_d[p] = 1'b0;
      err_d[p]    = 1'b0;
      if (gnt[p]) begin
        rvalid_d[p] = 1'b1;
        if (oor[p]) begin
          do_d[p]  = '0;
          err_d[p] = 1'b1;
        end else begin
          do_d[p] = mem[addr[p]];
          if (RDW_MODE == WRITE_THROUGH) begin
            for (int unsigned i = 0; i < NB; i++) begin
              if (we[p][i]) do_d[p][BYTE_W*i +: BYTE_W] = di[p][BYTE_W*i +: BYTE_W];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      do_q     <= '0;
      rvalid_q <= '0;
      err_q    <= '0;
    end else begin
      do_q     <= do_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  // Port B lanes are applied first so port A's later assignment wins per lane.
  always_ff @(posedge CLK) begin
    if (state == INIT) begin
      mem[fill_cnt] <= '0;
    end else begin
      for (int unsigned k = 0; k < NP; k++) begin
        for (int unsigned i = 0; i < NB; i++) begin
          if (wr_lanes[NP-1-k][i]) begin
            mem[addr[NP-1-k]][BYTE_W*i +: BYTE_W] <= di[NP-1-k][BYTE_W*i +: BYTE_W];
          end
        end
      end
    end
  end

  assign GNT_A    = gnt[0];
  assign GNT_B    = gnt[1];
  assign Do_A     = RST ? '0 : do_q[0];
  assign Do_B     = RST ? '0 : do_q[1];
  assign RVALID_A = RST ? 1'b0 : rvalid_q[0];
  assign RVALID_B = RST ? 1'b0 : rvalid_q[1];
  assign ERR_A    = RST ? 1'b0 : err_q[0];
  assign ERR_B    = RST ? 1'b0 : err_q[1];

endmodule

// File: tb/tb_dffram_dp.sv
// Bench for dffram_dp: two instances share stimulus.
//   u_dut0 : DEPTH=16, CLEAR_ON_RESET=1, READ_FIRST
//   u_dut1 : DEPTH=12, CLEAR_ON_RESET=0, WRITE_THROUGH (addresses 12..15 out of range)
module tb_dffram_dp;
   import dffram_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        en_a, en_b;
   logic [3:0]  we_a, we_b, a_a, a_b;
   logic [31:0] di_a, di_b;
   logic [1:0]  gnt_a, gnt_b, rv_a, rv_b, err_a, err_b, busy;
   logic [31:0] do_a [2];
   logic [31:0] do_b [2];

   int n_vec = 0;
   int n_err = 0;

   // reference model: word contents, whether a word's value is known, expected outputs
   logic [31:0] mem_m  [2][16];
   bit          kn_m   [2][16];
   logic [31:0] exp_do [2][2];
   bit          exp_kn [2][2];
   bit          exp_rv [2][2];
   bit          exp_err[2][2];

   always #5 clk = ~clk;

   dffram_dp #(.DW(32), .DEPTH(16), .CLEAR_ON_RESET(1'b1), .RDW_MODE(READ_FIRST)) u_dut0 (
      .CLK(clk), .RST(rst),
      .EN_A(en_a), .WE_A(we_a), .A_A(a_a), .Di_A(di_a),
      .GNT_A(gnt_a[0]), .Do_A(do_a[0]), .RVALID_A(rv_a[0]), .ERR_A(err_a[0]),
      .EN_B(en_b), .WE_B(we_b), .A_B(a_b), .Di_B(di_b),
      .GNT_B(gnt_b[0]), .Do_B(do_b[0]), .RVALID_B(rv_b[0]), .ERR_B(err_b[0]),
      .BUSY(busy[0]));

   dffram_dp #(.DW(32), .DEPTH(12), .CLEAR_ON_RESET(1'b0), .RDW_MODE(WRITE_THROUGH)) u_dut1 (
      .CLK(clk), .RST(rst),
      .EN_A(en_a), .WE_A(we_a), .A_A(a_a), .Di_A(di_a),
      .GNT_A(gnt_a[1]), .Do_A(do_a[1]), .RVALID_A(rv_a[1]), .ERR_A(err_a[1]),
      .EN_B(en_b), .WE_B(we_b), .A_B(a_b), .Di_B(di_b),
      .GNT_B(gnt_b[1]), .Do_B(do_b[1]), .RVALID_B(rv_b[1]), .ERR_B(err_b[1]),
      .BUSY(busy[1]));

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int depth_of(input int d);
      return (d == 0) ? 16 : 12;
   endfunction

   function automatic bit wt_of(input int d);
      return (d == 1);
   endfunction

   function automatic string pn(input int p);
      return (p == 0) ? "A" : "B";
   endfunction

   function automatic logic [31:0] got_do(input int d, input int p);
      return (p == 0) ? do_a[d] : do_b[d];
   endfunction

   function automatic logic got_rv(input int d, input int p);
      return (p == 0) ? rv_a[d] : rv_b[d];
   endfunction

   function automatic logic got_err(input int d, input int p);
      return (p == 0) ? err_a[d] : err_b[d];
   endfunction

   // byte-mask merge expressed as a bit mask: new bytes where the mask is set
   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                         input logic [3:0] m);
      logic [31:0] lm;
      lm = {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
      return (old & ~lm) | (nw & lm);
   endfunction

   function automatic logic [3:0] rnd_mask();
      case ($urandom_range(0, 3))
         0:       return 4'h0;
         1:       return 4'hF;
         default: return 4'($urandom_range(0, 15));
      endcase
   endfunction

   task automatic drive(input logic ea, input logic [3:0] wa, input logic [3:0] aa, input logic [31:0] da,
                        input logic eb, input logic [3:0] wb, input logic [3:0] ab, input logic [31:0] db);
      en_a = ea; we_a = wa; a_a = aa; di_a = da;
      en_b = eb; we_b = wb; a_b = ab; di_b = db;
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            exp_do[d][p]  = '0;
            exp_kn[d][p]  = 1'b1;
            exp_rv[d][p]  = 1'b0;
            exp_err[d][p] = 1'b0;
         end
      end
      for (int w = 0; w < 16; w++) begin
         mem_m[0][w] = '0;
         kn_m[0][w]  = 1'b1;
      end
   endtask

   // one clock of traffic with both instances READY; inputs already driven
   task automatic step();
      logic        en [2];
      logic [3:0]  ad [2];
      logic [3:0]  wm [2];
      logic [31:0] dd [2];
      logic [31:0] old;
      en[0] = en_a; ad[0] = a_a; wm[0] = we_a; dd[0] = di_a;
      en[1] = en_b; ad[1] = a_b; wm[1] = we_b; dd[1] = di_b;
      for (int d = 0; d < 2; d++) begin
         for (int p = 0; p < 2; p++) begin
            exp_rv[d][p]  = en[p];
            exp_err[d][p] = 1'b0;
            if (en[p]) begin
               if (int'(ad[p]) >= depth_of(d)) begin
                  exp_err[d][p] = 1'b1;
                  exp_do[d][p]  = '0;
                  exp_kn[d][p]  = 1'b1;
               end else begin
                  old = mem_m[d][ad[p]];
                  if (wt_of(d)) begin
                     exp_do[d][p] = merge(old, dd[p], wm[p]);
                     exp_kn[d][p] = kn_m[d][ad[p]] || (wm[p] == 4'hF);
                  end else begin
                     exp_do[d][p] = old;
                     exp_kn[d][p] = kn_m[d][ad[p]];
                  end
               end
            end
         end
         for (int p = 1; p >= 0; p--) begin
            if (en[p] && int'(ad[p]) < depth_of(d)) begin
               mem_m[d][ad[p]] = merge(mem_m[d][ad[p]], dd[p], wm[p]);
               if (wm[p] == 4'hF) kn_m[d][ad[p]] = 1'b1;
            end
         end
      end
      #1;
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("d%0d_gnt_A", d), 32'(gnt_a[d]), 32'(en_a));
         check_eq($sformatf("d%0d_gnt_B", d), 32'(gnt_b[d]), 32'(en_b));
      end
      @(posedge clk); #1;
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("d%0d_busy", d), 32'(busy[d]), 32'd0);
         for (int p = 0; p < 2; p++) begin
            check_eq($sformatf("d%0d_%s_rvalid", d, pn(p)), 32'(got_rv(d, p)), 32'(exp_rv[d][p]));
            check_eq($sformatf("d%0d_%s_err", d, pn(p)), 32'(got_err(d, p)), 32'(exp_err[d][p]));
            if (exp_kn[d][p])
               check_eq($sformatf("d%0d_%s_do", d, pn(p)), got_do(d, p), exp_do[d][p]);
         end
      end
   endtask

   task automatic check_quiet(input string tag);
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("%s_d%0d_busy", tag, d), 32'(busy[d]), 32'd1);
         check_eq($sformatf("%s_d%0d_gnt_A", tag, d), 32'(gnt_a[d]), 32'd0);
         check_eq($sformatf("%s_d%0d_gnt_B", tag, d), 32'(gnt_b[d]), 32'd0);
         for (int p = 0; p < 2; p++) begin
            check_eq($sformatf("%s_d%0d_%s_rvalid", tag, d, pn(p)), 32'(got_rv(d, p)), 32'd0);
            check_eq($sformatf("%s_d%0d_%s_err", tag, d, pn(p)), 32'(got_err(d, p)), 32'd0);
            check_eq($sformatf("%s_d%0d_%s_do", tag, d, pn(p)), got_do(d, p), 32'd0);
         end
      end
      check_eq({tag, "_d0_cnt"}, 32'(u_dut0.fill_cnt), 32'd0);
      check_eq({tag, "_d1_cnt"}, 32'(u_dut1.fill_cnt), 32'd0);
   endtask

   // one RST cycle, then the following cycle (requests there must be dropped);
   // returns #1 after the first edge that samples RST low
   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      check_quiet("rst");
      @(posedge clk); #1;
      rst = 1'b0;
      drive(1'b1, 4'h0, 4'd1, '0, 1'b1, 4'h0, 4'd2, '0);
      #1;
      check_quiet("post_rst");
      model_reset();
      @(posedge clk); #1;
      drive(1'b0, 4'h0, 4'd0, '0, 1'b0, 4'h0, 4'd0, '0);
      for (int d = 0; d < 2; d++) begin
         check_eq($sformatf("dropped_d%0d_A", d), 32'(rv_a[d]), 32'd0);
         check_eq($sformatf("dropped_d%0d_B", d), 32'(rv_b[d]), 32'd0);
      end
   endtask

   task automatic wait_ready();
      int c0 = 0;
      int c1 = 0;
      for (int k = 0; k < 40; k++) begin
         if (busy[0]) c0++;
         if (busy[1]) c1++;
         if (!busy[0] && !busy[1]) break;
         @(posedge clk); #1;
      end
      check_eq("busy_cycles_d0", 32'(c0), 32'd16);
      check_eq("busy_cycles_d1", 32'(c1), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      drive(1'b0, 4'h0, 4'd0, '0, 1'b0, 4'h0, 4'd0, '0);
      for (int d = 0; d < 2; d++)
         for (int w = 0; w < 16; w++) begin
            mem_m[d][w] = '0;
            kn_m[d][w]  = 1'b0;
         end

      pulse_reset();
      wait_ready();

      // cleared array reads zero
      drive(1'b1, 4'h0, 4'd5, '0, 1'b0, 4'h0, 4'd0, '0); step();
      check_eq("cleared_word5", do_a[0], 32'h0);

      // give every word a defined value
      for (int w = 0; w < 16; w++) begin
         drive(1'b1, 4'hF, 4'(w), $urandom(), 1'b0, 4'h0, 4'd0, '0); step();
      end

      // partial byte write
      drive(1'b1, 4'hF, 4'd3, 32'hDEADBEEF, 1'b0, 4'h0, 4'd0, '0); step();
      drive(1'b1, 4'h2, 4'd3, 32'h00001200, 1'b0, 4'h0, 4'd0, '0); step();
      drive(1'b1, 4'h0, 4'd3, '0, 1'b0, 4'h0, 4'd0, '0); step();
      check_eq("lane_merge_d0", do_a[0], 32'hDEAD12EF);
      check_eq("lane_merge_d1", do_a[1], 32'hDEAD12EF);
      check_eq("lane_merge_rvalid", 32'(rv_a[0]), 32'd1);

      // same-address dual write, port A priority per lane
      drive(1'b1, 4'hF, 4'd7, 32'h11111111, 1'b1, 4'hF, 4'd7, 32'h22222222); step();
      drive(1'b1, 4'h0, 4'd7, '0, 1'b0, 4'h0, 4'd0, '0); step();
      check_eq("collide_full", do_a[0], 32'h11111111);
      drive(1'b1, 4'h1, 4'd7, 32'h11111111, 1'b1, 4'hF, 4'd7, 32'h22222222); step();
      drive(1'b1, 4'h0, 4'd7, '0, 1'b0, 4'h0, 4'd0, '0); step();
      check_eq("collide_lane", do_a[0], 32'h22222211);
      check_eq("collide_lane_d1", do_a[1], 32'h22222211);

      // same-port read-during-write
      drive(1'b1, 4'hF, 4'd2, 32'hAAAA5555, 1'b0, 4'h0, 4'd0, '0); step();
      drive(1'b1, 4'hF, 4'd2, 32'h12345678, 1'b0, 4'h0, 4'd0, '0); step();
      check_eq("rdw_read_first", do_a[0], 32'hAAAA5555);
      check_eq("rdw_write_through", do_a[1], 32'h12345678);

      // out-of-range access on the 12-word instance
      drive(1'b0, 4'h0, 4'd0, '0, 1'b1, 4'h0, 4'd13, '0); step();
      check_eq("oor_do", do_b[1], 32'h0);
      check_eq("oor_err", 32'(err_b[1]), 32'd1);
      check_eq("oor_rvalid", 32'(rv_b[1]), 32'd1);
      drive(1'b0, 4'h0, 4'd0, '0, 1'b1, 4'hF, 4'd13, 32'hFFFFFFFF); step();
      drive(1'b0, 4'h0, 4'd0, '0, 1'b0, 4'h0, 4'd0, '0); step();
      check_eq("oor_err_clear", 32'(err_b[1]), 32'd0);
      check_eq("oor_rvalid_clear", 32'(rv_b[1]), 32'd0);
      drive(1'b1, 4'h0, 4'd1, '0, 1'b1, 4'h0, 4'd5, '0); step();

      repeat (300) begin
         drive(1'($urandom_range(0, 9) < 7), rnd_mask(), 4'($urandom_range(0, 15)), $urandom(),
               1'($urandom_range(0, 9) < 7), rnd_mask(), 4'($urandom_range(0, 15)), $urandom());
         step();
      end

      // reset while READY: pending read result dropped, write in RST cycle ignored
      drive(1'b1, 4'h0, 4'd4, '0, 1'b0, 4'h0, 4'd0, '0);
      @(posedge clk); #1;
      drive(1'b1, 4'hF, 4'd4, 32'hCAFEF00D, 1'b1, 4'hF, 4'd5, 32'h0BADF00D);
      pulse_reset();
      wait_ready();
      drive(1'b1, 4'h0, 4'd4, '0, 1'b1, 4'h0, 4'd5, '0); step();

      // reset in the middle of the zero-fill restarts it
      pulse_reset();
      repeat (9) begin
         @(posedge clk); #1;
      end
      check_eq("fill_cnt_before_abort", 32'(u_dut0.fill_cnt), 32'd9);
      check_eq("busy_before_abort", 32'(busy[0]), 32'd1);
      pulse_reset();
      wait_ready();

      repeat (60) begin
         drive(1'($urandom_range(0, 9) < 7), rnd_mask(), 4'($urandom_range(0, 15)), $urandom(),
               1'($urandom_range(0, 9) < 7), rnd_mask(), 4'($urandom_range(0, 15)), $urandom());
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
